// File: rtl/pwm_pkg.sv
// Shared constants and duty helpers for the PWM generator.
// The ramp helper moves a duty value toward a target without overshooting it.
package pwm_pkg;
  localparam int DUTY_W = 8;
  localparam int STEPS  = 100;
  localparam int STEP_W = 7;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 8'd100;

  typedef logic [DUTY_W-1:0] duty_t;

  function automatic duty_t clamp_duty(input duty_t d);
    duty_t r;
    r = (d > DUTY_MAX) ? DUTY_MAX : d;
    return r;
  endfunction

  // The difference is kept 9 bits wide so a downward move never wraps.
  function automatic duty_t ramp_toward(input duty_t cur, input duty_t tgt, input duty_t step);
    logic [DUTY_W:0] diff;
    duty_t           r;
    r = tgt;
    if (step != '0) begin
      if (tgt >= cur) begin
        diff = {1'b0, tgt} - {1'b0, cur};
        if (diff > {1'b0, step}) r = cur + step;
      end else begin
        diff = {1'b0, cur} - {1'b0, tgt};
        if (diff > {1'b0, step}) r = cur - step;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/pwm_generator_if.sv
// Duty-in / PWM-out bundle between the duty selector, the generator and the pin driver.
interface pwm_generator_if;
  import pwm_pkg::*;
  logic  enable;
  duty_t dutyCycle;
  logic  pwmOut;
  logic  periodStart;
  duty_t activeDuty;

  modport master (output enable, dutyCycle, input pwmOut, periodStart, activeDuty);
  modport slave  (input enable, dutyCycle, output pwmOut, periodStart, activeDuty);
endinterface

// File: rtl/pwm_prescaler.sv
// Free-running 0..PRESCALE-1 counter; tick marks the last cycle of each PWM step.
module pwm_prescaler #(
  parameter int PRESCALE = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + PW'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/pwm_generator.sv
// Left-aligned 100-step PWM; duty is (optionally slew-limited and) loaded only at
// period boundaries or on the first enabled cycle, so pulses are never truncated.
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int PRESCALE  = 500,
  parameter int RAMP_STEP = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  pwm_generator_if.slave  bus
);
  localparam duty_t             RAMP      = DUTY_W'(RAMP_STEP);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  logic              tick, load, clear;
  logic [STEP_W-1:0] stepCnt_q, stepCnt_d;
  duty_t             activeDuty_q, activeDuty_d;
  logic              pwmOut_q, pwmOut_d;
  logic              periodStart_q, periodStart_d;
  logic              pending_q, pending_d;

  // pending_q marks that the next enabled cycle must load, even mid-count.
  assign load  = bus.enable && (pending_q || (tick && stepCnt_q == LAST_STEP));
  assign clear = !bus.enable || load;

  pwm_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .tick  (tick)
  );

  always_comb begin
    stepCnt_d     = stepCnt_q;
    activeDuty_d  = activeDuty_q;
    periodStart_d = 1'b0;
    pending_d     = pending_q;
    if (!bus.enable) begin
      stepCnt_d = '0;
      pending_d = 1'b1;
    end else if (load) begin
      stepCnt_d     = '0;
      pending_d     = 1'b0;
      activeDuty_d  = ramp_toward(activeDuty_q, clamp_duty(bus.dutyCycle), RAMP);
      periodStart_d = 1'b1;
    end else if (tick) begin
      stepCnt_d = stepCnt_q + STEP_W'(1);
    end
    // Compare against next-state values so duty 100 has no low cycle at the wrap.
    pwmOut_d = bus.enable && ({1'b0, stepCnt_d} < activeDuty_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stepCnt_q     <= '0;
      activeDuty_q  <= '0;
      pwmOut_q      <= 1'b0;
      periodStart_q <= 1'b0;
      pending_q     <= 1'b1;
    end else begin
      stepCnt_q     <= stepCnt_d;
      activeDuty_q  <= activeDuty_d;
      pwmOut_q      <= pwmOut_d;
      periodStart_q <= periodStart_d;
      pending_q     <= pending_d;
    end
  end

  assign bus.pwmOut      = pwmOut_q;
  assign bus.periodStart = periodStart_q;
  assign bus.activeDuty  = activeDuty_q;
endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench: PRESCALE=2 (200-clock periods); dut0 applies duty directly, dut1 ramps by 20.
module tb_pwm_generator;
  logic clk = 1'b0;
  logic rst_n0, rst_n1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pwm_generator_if bus0();
  pwm_generator_if bus1();

  pwm_generator #(.PRESCALE(2), .RAMP_STEP(0))  dut0 (.clk(clk), .rst_n(rst_n0), .bus(bus0));
  pwm_generator #(.PRESCALE(2), .RAMP_STEP(20)) dut1 (.clk(clk), .rst_n(rst_n1), .bus(bus1));

  // Samples one 200-clock period of dut0 starting at its periodStart cycle,
  // optionally changing dutyCycle at sample chg_at; ends on the next period's first cycle.
  task automatic run_period0(input int chg_at, input logic [7:0] chg_val,
                             output int hi, output int extra_ps);
    hi = 0; extra_ps = 0;
    for (int i = 0; i < 200; i++) begin
      if (i == chg_at) bus0.dutyCycle = chg_val;
      if (bus0.pwmOut) hi++;
      if (i > 0 && bus0.periodStart) extra_ps++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    bus0.enable = 1'b0; bus0.dutyCycle = 8'd0;
    bus1.enable = 1'b0; bus1.dutyCycle = 8'd0;
    repeat (3) @(negedge clk);
    total++; if (bus0.pwmOut !== 1'b0) begin bad++; $display("FAIL reset_pwm got=%0b exp=0", bus0.pwmOut); end
    total++; if (bus0.periodStart !== 1'b0) begin bad++; $display("FAIL reset_ps got=%0b exp=0", bus0.periodStart); end
    total++; if (bus0.activeDuty !== 8'd0) begin bad++; $display("FAIL reset_duty got=%0d exp=0", bus0.activeDuty); end
    total++; if (bus1.activeDuty !== 8'd0) begin bad++; $display("FAIL reset_duty1 got=%0d exp=0", bus1.activeDuty); end
  endtask

  task automatic test_basic;
    int hi, ex;
    bus0.dutyCycle = 8'd30; bus0.enable = 1'b1; rst_n0 = 1'b1;
    @(negedge clk);
    total++; if (bus0.periodStart !== 1'b1) begin bad++; $display("FAIL basic_first_ps got=%0b exp=1", bus0.periodStart); end
    total++; if (bus0.activeDuty !== 8'd30) begin bad++; $display("FAIL basic_duty got=%0d exp=30", bus0.activeDuty); end
    total++; if (bus0.pwmOut !== 1'b1) begin bad++; $display("FAIL basic_pwm_start got=%0b exp=1", bus0.pwmOut); end
    for (int p = 0; p < 2; p++) begin
      run_period0(-1, 8'd0, hi, ex);
      total++; if (hi !== 60) begin bad++; $display("FAIL basic_high p%0d got=%0d exp=60", p, hi); end
      total++; if (ex !== 0) begin bad++; $display("FAIL basic_extra_ps p%0d got=%0d exp=0", p, ex); end
      total++; if (bus0.periodStart !== 1'b1) begin bad++; $display("FAIL basic_next_ps p%0d got=%0b exp=1", p, bus0.periodStart); end
    end
  endtask

  task automatic test_mid_change;
    int hi, ex;
    run_period0(80, 8'd70, hi, ex);
    total++; if (hi !== 60) begin bad++; $display("FAIL mid_keep got=%0d exp=60", hi); end
    total++; if (bus0.activeDuty !== 8'd70) begin bad++; $display("FAIL mid_load got=%0d exp=70", bus0.activeDuty); end
    run_period0(-1, 8'd0, hi, ex);
    total++; if (hi !== 140) begin bad++; $display("FAIL mid_new got=%0d exp=140", hi); end
  endtask

  task automatic test_boundaries;
    int hi, ex, sum;
    run_period0(0, 8'd0, hi, ex);
    total++; if (hi !== 140) begin bad++; $display("FAIL bnd_pre0 got=%0d exp=140", hi); end
    total++; if (bus0.activeDuty !== 8'd0) begin bad++; $display("FAIL bnd_duty0 got=%0d exp=0", bus0.activeDuty); end
    run_period0(0, 8'd100, hi, ex);
    total++; if (hi !== 0) begin bad++; $display("FAIL bnd_zero_high got=%0d exp=0", hi); end
    total++; if (bus0.activeDuty !== 8'd100) begin bad++; $display("FAIL bnd_duty100 got=%0d exp=100", bus0.activeDuty); end
    sum = 0;
    for (int p = 0; p < 3; p++) begin
      run_period0((p == 0) ? 0 : -1, 8'd200, hi, ex);
      sum += hi;
      total++; if (bus0.periodStart !== 1'b1) begin bad++; $display("FAIL bnd_ps p%0d got=%0b exp=1", p, bus0.periodStart); end
    end
    total++; if (sum !== 600) begin bad++; $display("FAIL bnd_full_high got=%0d exp=600", sum); end
    total++; if (bus0.pwmOut !== 1'b1) begin bad++; $display("FAIL bnd_wrap_high got=%0b exp=1", bus0.pwmOut); end
    total++; if (bus0.activeDuty !== 8'd100) begin bad++; $display("FAIL bnd_clamp got=%0d exp=100", bus0.activeDuty); end
  endtask

  task automatic test_enable_drop;
    int hi, ex;
    run_period0(0, 8'd50, hi, ex);
    total++; if (hi !== 200) begin bad++; $display("FAIL en_pre got=%0d exp=200", hi); end
    total++; if (bus0.activeDuty !== 8'd50) begin bad++; $display("FAIL en_duty got=%0d exp=50", bus0.activeDuty); end
    repeat (30) @(negedge clk);
    total++; if (bus0.pwmOut !== 1'b1) begin bad++; $display("FAIL en_high_phase got=%0b exp=1", bus0.pwmOut); end
    bus0.enable = 1'b0;
    @(negedge clk);
    total++; if (bus0.pwmOut !== 1'b0) begin bad++; $display("FAIL en_off_pwm got=%0b exp=0", bus0.pwmOut); end
    total++; if (bus0.activeDuty !== 8'd50) begin bad++; $display("FAIL en_off_hold got=%0d exp=50", bus0.activeDuty); end
    repeat (5) @(negedge clk);
    total++; if (bus0.pwmOut !== 1'b0 || bus0.periodStart !== 1'b0) begin
      bad++; $display("FAIL en_off_idle got=%0b%0b exp=00", bus0.pwmOut, bus0.periodStart); end
    bus0.enable = 1'b1;
    @(negedge clk);
    total++; if (bus0.periodStart !== 1'b1) begin bad++; $display("FAIL en_re_ps got=%0b exp=1", bus0.periodStart); end
    total++; if (bus0.activeDuty !== 8'd50) begin bad++; $display("FAIL en_re_duty got=%0d exp=50", bus0.activeDuty); end
    run_period0(-1, 8'd0, hi, ex);
    total++; if (hi !== 100) begin bad++; $display("FAIL en_re_high got=%0d exp=100", hi); end
  endtask

  task automatic test_reset_mid;
    int hi, ex;
    run_period0(0, 8'd80, hi, ex);
    total++; if (hi !== 100) begin bad++; $display("FAIL rst_pre got=%0d exp=100", hi); end
    repeat (20) @(negedge clk);
    rst_n0 = 1'b0; bus0.dutyCycle = 8'd40;
    @(negedge clk);
    total++; if (bus0.pwmOut !== 1'b0) begin bad++; $display("FAIL rst_mid_pwm got=%0b exp=0", bus0.pwmOut); end
    total++; if (bus0.activeDuty !== 8'd0) begin bad++; $display("FAIL rst_mid_duty got=%0d exp=0", bus0.activeDuty); end
    total++; if (bus0.periodStart !== 1'b0) begin bad++; $display("FAIL rst_mid_ps got=%0b exp=0", bus0.periodStart); end
    rst_n0 = 1'b1;
    @(negedge clk);
    total++; if (bus0.periodStart !== 1'b1) begin bad++; $display("FAIL rst_rel_ps got=%0b exp=1", bus0.periodStart); end
    total++; if (bus0.activeDuty !== 8'd40) begin bad++; $display("FAIL rst_rel_duty got=%0d exp=40", bus0.activeDuty); end
    run_period0(-1, 8'd0, hi, ex);
    total++; if (hi !== 80) begin bad++; $display("FAIL rst_rel_high got=%0d exp=80", hi); end
  endtask

  task automatic test_ramp;
    int exp_seq[10] = '{20, 40, 60, 80, 100, 80, 60, 40, 20, 10};
    int hi;
    bus1.dutyCycle = 8'd100; bus1.enable = 1'b1; rst_n1 = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      total++; if (bus1.periodStart !== 1'b1 || bus1.activeDuty !== 8'(exp_seq[k])) begin
        bad++; $display("FAIL ramp_step%0d got=%0d ps=%0b exp=%0d", k, bus1.activeDuty, bus1.periodStart, exp_seq[k]); end
      if (k == 4) bus1.dutyCycle = 8'd10;
      hi = 0;
      for (int i = 0; i < 200; i++) begin
        if (bus1.pwmOut) hi++;
        @(negedge clk);
      end
      total++; if (hi !== 2 * exp_seq[k]) begin bad++; $display("FAIL ramp_high%0d got=%0d exp=%0d", k, hi, 2 * exp_seq[k]); end
    end
    total++; if (bus1.activeDuty !== 8'd10) begin bad++; $display("FAIL ramp_settle got=%0d exp=10", bus1.activeDuty); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mid_change();
    test_boundaries();
    test_enable_drop();
    test_reset_mid();
    test_ramp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pwm_generator.md
# pwm_generator

Consumes the 8-bit percent duty value from the push-button duty selector (0–100 in steps of 10) and drives a fixed-frequency PWM output. The duty value is applied only at period boundaries, optionally slew-limited, so button presses never produce runt or glitched pulses. Sits between the duty selector and the motor/LED driver pin.

## Interface
- PRESCALE, 500: clock cycles per PWM step (≥2); the period is 100 steps = 100·PRESCALE clocks.
- RAMP_STEP, 0: maximum change of active duty per period, in percent; 0 means apply target immediately.
- clk  input  1  system clock; one clock domain.
- rst_n  input  1  reset, synchronous, active-low.
- enable  input  1  run PWM when high; force idle when low.
- dutyCycle  input  8  target duty in percent; values >100 clamp to 100.
- pwmOut  output  1  PWM output, registered.
- periodStart  output  1  one-cycle pulse when a new period begins and active duty is loaded.
- activeDuty  output  8  duty (percent) currently in effect.

## Operation
- Prescaler preCnt counts 0..PRESCALE-1 and wraps. tick = (preCnt == PRESCALE-1).
- Step counter stepCnt counts 0..99. It advances on tick and wraps 99→0.
- target = min(dutyCycle, 100), sampled combinationally at each load instant only; changes mid-period are ignored.
- Load instant (L) occurs on tick with stepCnt==99, or on the first enabled cycle after reset or after enable was low.
- At L:
  - RAMP_STEP==0: activeDuty ← target.
  - Otherwise activeDuty moves toward target by min(RAMP_STEP, |target−activeDuty|). Compute the difference 9 bits wide; no wrap below 0 or above 100.
- pwmOut register ← enable && (next stepCnt < next activeDuty). Duty 0 → constant low. Duty 100 → constant high, with no low cycle at the period boundary.
- Per period, pwmOut is high for exactly activeDuty·PRESCALE clocks, starting at step 0 (left-aligned).
- enable low:
  - preCnt and stepCnt held at 0; pwmOut ← 0; periodStart ← 0.
  - activeDuty holds its value.
- enable rising: the first enabled cycle is a load instant. Ramp starts from the held activeDuty. preCnt=0 and stepCnt=0 in that cycle.
- Reset (rst_n low at a clk edge, at any time including mid-period): preCnt=0, stepCnt=0, activeDuty=0, pwmOut=0, periodStart=0. The first enabled cycle after reset release is a load instant.

## Timing
- All outputs are registered and update on the clk rising edge.
- periodStart is high for the single cycle in which stepCnt==0 and preCnt==0 after a load.
- activeDuty shows its new value in that same cycle.
- pwmOut reflects the new period's duty in the same cycle as periodStart (next-state computed).
- Latency from a dutyCycle change to its effect: up to one full period (100·PRESCALE clocks) plus 0 cycles after L.
- With ramp, reaching the target takes ceil(|Δ|/RAMP_STEP) periods.
- Same-cycle events:
  - Simultaneous tick at step 99 and dutyCycle change: the value present in that cycle is the one loaded.
  - enable falling in the same cycle as L: idle wins and no load occurs.

## Structure
- Shared package pwm_pkg:
  - DUTY_W=8, STEPS=100, DUTY_MAX=8'd100.
  - Function clamp_duty (8→8).
  - Function ramp_toward(current, target, step).
- Optional sub-module pwm_prescaler (PRESCALE parameter; outputs tick; inputs clk, rst_n, clear). The step counter, load logic and output stay in pwm_generator.
- Estimated size: ~150–250 lines RTL.

## Test plan
Benches use PRESCALE=2, so one period is 200 clocks.
- Reset then enable=1, dutyCycle=30, RAMP_STEP=0:
  - periodStart in the first enabled cycle, activeDuty=30.
  - pwmOut high 60 clocks, low 140, repeating.
- dutyCycle 30→70 at step 40:
  - Current period stays at 60 high clocks.
  - Next periodStart loads 70; 140 high clocks.
- Boundaries: duty 0 → pwmOut never high. Duty 100 → pwmOut continuously high across ≥3 periods. dutyCycle=200 → activeDuty=100.
- RAMP_STEP=20, activeDuty=0, target=100: activeDuty goes 20,40,60,80,100 on successive periodStarts. Then target=10 gives 80,60,40,20,10.
- enable dropped mid-period at duty 50:
  - pwmOut=0 the next cycle; activeDuty holds 50.
  - Re-enable: periodStart in the first enabled cycle, 100 high clocks.
- rst_n low for 1 cycle mid high phase:
  - All outputs 0 after the edge.
  - After release with enable=1: load in the first cycle, activeDuty=dutyCycle (RAMP_STEP=0).
